axi_fb_read_slave: RTL

AXI_FB_READ_SLAVE -- requirements
Module: axi_fb_read_slave

---
 rtl/vga_axi_pkg.sv | 27 ++
 rtl/axi_fb_read_slave_if.sv | 31 +++
 rtl/fb_mem.sv | 28 ++
 rtl/axi_fb_read_slave.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vga_axi_pkg.sv
// Shared constants for the frame-buffer AXI read slave: burst types,
// response codes, the only supported beat size and the control state encoding.
package vga_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_8B     = 3'd3;
    localparam int         BEAT_BYTES  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } fbState_t;

    // Only 8-byte FIXED and INCR bursts return real data; anything else is
    // answered beat by beat with SLVERR.
    function automatic logic burstSupported(input logic [1:0] burst,
                                            input logic [2:0] size);
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == SIZE_8B);
    endfunction

endpackage

// File: rtl/axi_fb_read_slave_if.sv
// AXI read address and read data channels between a master and the frame-buffer
// read slave. Signal suffixes are written from the slave's point of view.
interface axi_fb_read_slave_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);

    logic [ADDR_WIDTH-1:0] araddr_i;
    logic [1:0]            arburst_i;
    logic [7:0]            arlen_i;
    logic [2:0]            arsize_i;
    logic                  arvalid_i;
    logic                  arready_o;

    logic [DATA_WIDTH-1:0] rdata_o;
    logic [1:0]            rresp_o;
    logic                  rlast_o;
    logic                  rvalid_o;
    logic                  rready_i;

    modport slave (
        input  araddr_i, arburst_i, arlen_i, arsize_i, arvalid_i, rready_i,
        output arready_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );

    modport master (
        output araddr_i, arburst_i, arlen_i, arsize_i, arvalid_i, rready_i,
        input  arready_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );

endinterface

// File: rtl/fb_mem.sv
// Frame store: plain register array, written synchronously by the preload port
// and read combinationally so a beat can capture its word at launch time.
// Contents are deliberately not reset.
module fb_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024,
    parameter int IDX_WIDTH  = 10
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [IDX_WIDTH-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [IDX_WIDTH-1:0]  rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Preload write lands on the clock edge.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axi_fb_read_slave.sv
// AXI read-only slave in front of a preloadable frame store. One burst at a
// time: accept AR in IDLE, stream arlen+1 beats with registered R outputs in
// BURST, then go back to IDLE. Out-of-range beats and unsupported bursts are
// answered with SLVERR and zero data, never truncated.
module axi_fb_read_slave
    import vga_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    localparam int                   IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                    clk_a,
    input  logic                    rst_a,
    axi_fb_read_slave_if.slave      bus,
    input  logic                    wr_en_i,
    input  logic [IDX_WIDTH-1:0]    wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(BEAT_BYTES);

    fbState_t              state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] beatAddr_q;
    logic [1:0]            burst_q;
    logic [7:0]            len_q;
    logic [7:0]            beatCnt_q;
    logic                  burstErr_q;

    logic                  arAccept;
    logic [7:0]            beatCnt_d;
    logic [ADDR_WIDTH-1:0] launchAddr_d;
    logic [ADDR_WIDTH-1:0] launchOffset;
    logic                  launchErr_d;
    logic                  launchLast_d;
    logic                  launchInRange;
    logic [IDX_WIDTH-1:0]  rdIdx;
    logic [DATA_WIDTH-1:0] memWord;
    logic                  launchOk;
    logic [DATA_WIDTH-1:0] launchData_d;
    logic [1:0]            launchResp_d;

    fb_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_mem (
        .clk_i      (clk_a),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rd_addr_i  (rdIdx),
        .rd_data_o  (memWord)
    );

    // Work out which beat would be launched at the next edge: the first beat
    // of a newly accepted burst, or the successor of the beat now on the bus.
    always_comb begin
        arAccept     = bus.arvalid_i && arready_q;
        beatCnt_d    = beatCnt_q + 8'd1;
        launchAddr_d = beatAddr_q;
        launchErr_d  = burstErr_q;
        launchLast_d = (beatCnt_d == len_q);
        if (arAccept) begin
            launchAddr_d = bus.araddr_i;
            launchErr_d  = !burstSupported(bus.arburst_i, bus.arsize_i);
            launchLast_d = (bus.arlen_i == 8'd0);
        end else if (burst_q == BURST_INCR) begin
            launchAddr_d = beatAddr_q + ADDR_STEP;
        end
        launchOffset  = launchAddr_d - BASE_ADDR;
        launchInRange = (launchAddr_d >= BASE_ADDR) && ((launchOffset >> 3) < DEPTH_LIMIT);
        rdIdx         = launchOffset[IDX_WIDTH+2:3];
    end

    assign launchOk     = launchInRange && !launchErr_d;
    assign launchData_d = launchOk ? memWord : '0;
    assign launchResp_d = launchOk ? RESP_OKAY : RESP_SLVERR;

    // Control FSM with registered handshake and read-data outputs.
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            state_q    <= ST_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            beatAddr_q <= '0;
            burst_q    <= BURST_FIXED;
            len_q      <= 8'd0;
            beatCnt_q  <= 8'd0;
            burstErr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arAccept) begin
                        state_q    <= ST_BURST;
                        arready_q  <= 1'b0;
                        burst_q    <= bus.arburst_i;
                        len_q      <= bus.arlen_i;
                        beatCnt_q  <= 8'd0;
                        burstErr_q <= launchErr_d;
                        beatAddr_q <= launchAddr_d;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= launchData_d;
                        rresp_q    <= launchResp_d;
                        rlast_q    <= launchLast_d;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (rvalid_q && bus.rready_i) begin
                        if (rlast_q) begin
                            state_q  <= ST_IDLE;
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            rresp_q  <= RESP_OKAY;
                            rdata_q  <= '0;
                        end else begin
                            beatCnt_q  <= beatCnt_d;
                            beatAddr_q <= launchAddr_d;
                            rdata_q    <= launchData_d;
                            rresp_q    <= launchResp_d;
                            rlast_q    <= launchLast_d;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arready_o = arready_q;
    assign bus.rvalid_o  = rvalid_q;
    assign bus.rlast_o   = rlast_q;
    assign bus.rresp_o   = rresp_q;
    assign bus.rdata_o   = rdata_q;

endmodule
